// File: rtl/tail_light_decoder.sv
// rtl/tail_light_decoder.sv - taillight lamp-bus monitor recovering brake/turn commands
// Optional feature macro: STEP_TIMING_CHECK_EN (step timing check inside a running sequence).
module tail_light_decoder #(
  parameter int STEP_CYCLES = 5,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] right_light,
  input  logic [2:0] left_light,
  output logic       brake,
  output logic       turn_right,
  output logic       turn_left,
  output logic       valid,
  output logic       seq_error,
  output logic [7:0] error_count
);

  typedef enum logic [2:0] {
    ST_PENDING, ST_IDLE, ST_BRAKE, ST_TURN_R, ST_TURN_L, ST_BRAKE_R, ST_BRAKE_L
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_STEP = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_MAX  = CNT_W'(STEP_CYCLES + 1);

  state_t           state_q, state_d, cls;
  logic [2:0]       prev_r_q, prev_l_q;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             changed;

  // turn sequence successor: 001->011->111->000->001
  function automatic logic is_nt(input logic [2:0] from, input logic [2:0] to);
    case (from)
      3'b001:  is_nt = (to == 3'b011);
      3'b011:  is_nt = (to == 3'b111);
      3'b111:  is_nt = (to == 3'b000);
      3'b000:  is_nt = (to == 3'b001);
      default: is_nt = 1'b0;
    endcase
  endfunction

  // brake+turn sequence successor: 111->110->100->000->111
  function automatic logic is_nb(input logic [2:0] from, input logic [2:0] to);
    case (from)
      3'b111:  is_nb = (to == 3'b110);
      3'b110:  is_nb = (to == 3'b100);
      3'b100:  is_nb = (to == 3'b000);
      3'b000:  is_nb = (to == 3'b111);
      default: is_nb = 1'b0;
    endcase
  endfunction

  assign changed = (right_light != prev_r_q) || (left_light != prev_l_q);

  always_comb begin
    cls       = ST_PENDING;
    state_d   = state_q;
    dwell_d   = dwell_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    cmd_d     = 4'b0000;

    if (left_light == 3'b000 && prev_l_q == 3'b000 && is_nt(prev_r_q, right_light))
      cls = ST_TURN_R;
    else if (right_light == 3'b000 && prev_r_q == 3'b000 && is_nt(prev_l_q, left_light))
      cls = ST_TURN_L;
    else if (left_light == 3'b111 && prev_l_q == 3'b111 && is_nb(prev_r_q, right_light))
      cls = ST_BRAKE_R;
    else if (right_light == 3'b111 && prev_r_q == 3'b111 && is_nb(prev_l_q, left_light))
      cls = ST_BRAKE_L;

    if (changed) begin
      dwell_d = DWELL_ONE;
      state_d = cls;
`ifdef STEP_TIMING_CHECK_EN
      // only steps inside an already-running sequence are timed
      if (cls != ST_PENDING && cls == state_q && dwell_q != DWELL_STEP) begin
        state_d = ST_PENDING;
        err_d   = 1'b1;
      end
`endif
    end else begin
      dwell_d = (dwell_q >= DWELL_MAX) ? DWELL_MAX : dwell_q + CNT_W'(1);
      if (dwell_q == DWELL_STEP) begin
        if (right_light == 3'b000 && left_light == 3'b000) begin
          state_d = ST_IDLE;
        end else if (right_light == 3'b111 && left_light == 3'b111) begin
          state_d = ST_BRAKE;
        end else begin
          state_d = ST_PENDING;
          err_d   = 1'b1;
        end
      end
    end

    if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    // {brake, turn_right, turn_left, valid}
    case (state_d)
      ST_IDLE:    cmd_d = 4'b0001;
      ST_BRAKE:   cmd_d = 4'b1001;
      ST_TURN_R:  cmd_d = 4'b0101;
      ST_TURN_L:  cmd_d = 4'b0011;
      ST_BRAKE_R: cmd_d = 4'b1101;
      ST_BRAKE_L: cmd_d = 4'b1011;
      default:    cmd_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PENDING;
      prev_r_q  <= 3'b000;
      prev_l_q  <= 3'b000;
      dwell_q   <= DWELL_ONE;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      cmd_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      prev_r_q  <= right_light;
      prev_l_q  <= left_light;
      dwell_q   <= dwell_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      cmd_q     <= cmd_d;
    end
  end

  assign brake       = cmd_q[3];
  assign turn_right  = cmd_q[2];
  assign turn_left   = cmd_q[1];
  assign valid       = cmd_q[0];
  assign seq_error   = err_q;
  assign error_count = err_cnt_q;

endmodule

// File: tb/tb_tail_light_decoder.sv
// tb/tb_tail_light_decoder.sv - randomized and directed bench for tail_light_decoder against a lamp-rule model
module tb_tail_light_decoder;
  localparam int STEP = 5;
`ifdef STEP_TIMING_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] right_light = 3'b000;
  logic [2:0] left_light = 3'b000;
  logic       brake, turn_right, turn_left, valid, seq_error;
  logic [7:0] error_count;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  tail_light_decoder #(.STEP_CYCLES(STEP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .right_light(right_light), .left_light(left_light),
    .brake(brake), .turn_right(turn_right), .turn_left(turn_left), .valid(valid),
    .seq_error(seq_error), .error_count(error_count)
  );

  always #5 clk = ~clk;

  // modes: 0 pending, 1 idle, 2 brake, 3 turn R, 4 turn L, 5 brake+R, 6 brake+L
  // expected {brake, turn_right, turn_left, valid} per mode
  logic [3:0] cmd_tbl [7] = '{4'b0000, 4'b0001, 4'b1001, 4'b0101, 4'b0011, 4'b1101, 4'b1011};
  int m_r, m_l, m_dwell, m_mode, m_cnt;
  bit m_err;

  function automatic int seq_next(bit is_brake, int v);
    int s[4];
    if (is_brake) s = '{7, 6, 4, 0};
    else          s = '{1, 3, 7, 0};
    for (int i = 0; i < 4; i++) if (s[i] == v) return s[(i + 1) % 4];
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int r, l, cls;
    r = int'(right_light);
    l = int'(left_light);
    if (rst) begin
      m_r = 0; m_l = 0; m_dwell = 1; m_mode = 0; m_cnt = 0; m_err = 1'b0;
      started = 1'b1;
    end else begin
      m_err = 1'b0;
      if (r != m_r || l != m_l) begin
        cls = 0;
        if      (l == 0 && m_l == 0 && r == seq_next(1'b0, m_r)) cls = 3;
        else if (r == 0 && m_r == 0 && l == seq_next(1'b0, m_l)) cls = 4;
        else if (l == 7 && m_l == 7 && r == seq_next(1'b1, m_r)) cls = 5;
        else if (r == 7 && m_r == 7 && l == seq_next(1'b1, m_l)) cls = 6;
        if (EN && cls != 0 && cls == m_mode && m_dwell != STEP) begin
          m_err = 1'b1; m_mode = 0;
        end else begin
          m_mode = cls;
        end
        m_dwell = 1;
      end else begin
        if (m_dwell == STEP) begin
          if (r == 0 && l == 0)      m_mode = 1;
          else if (r == 7 && l == 7) m_mode = 2;
          else begin m_mode = 0; m_err = 1'b1; end
        end
        if (m_dwell < STEP + 1) m_dwell++;
      end
      m_r = r; m_l = l;
      if (m_err && m_cnt < 255) m_cnt++;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started)
      check("cycle", {3'b0, brake, turn_right, turn_left, valid, seq_error, error_count},
            {3'b0, cmd_tbl[m_mode], m_err, 8'(m_cnt)});
  end

  task automatic drive(input int r, input int l, input int n);
    right_light = 3'(r);
    left_light  = 3'(l);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] cmd4();
    return {12'b0, brake, turn_right, turn_left, valid};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", {3'b0, brake, turn_right, turn_left, valid, seq_error, error_count}, 16'h0000);
    rst = 1'b0;

    drive(0, 0, 5);
    check("t1_idle", cmd4(), 16'h0001);

    drive(1, 0, 1);
    check("t2_turn_r_first", cmd4(), 16'h0005);
    drive(1, 0, 4);
    drive(3, 0, 5); drive(7, 0, 5); drive(0, 0, 5); drive(1, 0, 5);
    check("t2_turn_r_held", cmd4(), 16'h0005);
    check("t2_no_err", {8'b0, error_count}, 16'h0000);

    drive(7, 7, 6);
    check("t3_brake", cmd4(), 16'h0009);
    drive(6, 7, 1);
    check("t3_brake_r_first", cmd4(), 16'h000D);
    drive(6, 7, 4);
    drive(4, 7, 5); drive(0, 7, 5); drive(7, 7, 5);
    check("t3_brake_r_held", cmd4(), 16'h000D);

    drive(0, 0, 6);
    drive(0, 1, 3);
    check("t4_turn_l", cmd4(), 16'h0003);
    drive(0, 3, 1);
    if (EN) begin
      check("t4_en_cmd", cmd4(), 16'h0000);
      check("t4_en_err", {7'b0, seq_error, error_count}, 16'h0101);
    end else begin
      check("t4_dis_cmd", cmd4(), 16'h0003);
      check("t4_dis_err", {7'b0, seq_error, error_count}, 16'h0000);
    end
    drive(0, 3, 4);
    drive(0, 7, 5);

    drive(5, 2, 1);
    check("t5_pending", cmd4(), 16'h0000);
    drive(5, 2, 5);
    check("t5_hold_err", {7'b0, seq_error, error_count}, EN ? 16'h0102 : 16'h0101);

    drive(7, 7, 6);
    drive(7, 6, 2);
    check("t6_brake_l", cmd4(), 16'h000B);
    rst = 1'b1; right_light = 3'b000; left_light = 3'b000;
    @(negedge clk);
    check("t6_reset", {3'b0, brake, turn_right, turn_left, valid, seq_error, error_count}, 16'h0000);
    rst = 1'b0;
    drive(0, 0, 5);
    check("t6_idle_after", cmd4(), 16'h0001);

    for (int i = 0; i < 400; i++) begin
      int k, runs, r, l, n;
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      k = $urandom_range(0, 6);
      runs = $urandom_range(1, 6);
      for (int j = 0; j < runs; j++) begin
        case (k)
          0: begin r = seq_next(1'b0, int'(right_light)); if (r < 0) r = 1; l = 0; end
          1: begin l = seq_next(1'b0, int'(left_light));  if (l < 0) l = 1; r = 0; end
          2: begin r = seq_next(1'b1, int'(right_light)); if (r < 0) r = 7; l = 7; end
          3: begin l = seq_next(1'b1, int'(left_light));  if (l < 0) l = 7; r = 7; end
          4: begin r = 0; l = 0; end
          5: begin r = 7; l = 7; end
          default: begin r = int'($urandom_range(0, 7)); l = int'($urandom_range(0, 7)); end
        endcase
        n = ($urandom_range(0, 2) != 0) ? STEP : int'($urandom_range(1, 8));
        drive(r, l, n);
      end
    end

    for (int i = 0; i < 260; i++) begin
      if (i % 2 == 0) drive(5, 2, 6);
      else            drive(2, 5, 6);
    end
    check("sat_count", {7'b0, seq_error, error_count}, 16'h01FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
